pipe_stage_reg_discard: RTL and testbench
=========================================

# pipe_stage_reg_discard

Parametrised inter-stage pipeline register with multi-lane valid tracking, flush, an N-deep outstanding-response discard counter and a one-entry response hold buffer. It sits between two pipeline stages, typically EX→MEM. It latches the forward bus and carries per-lane valid bits. It also filters cache/RAM read responses, discarding those belonging to cancelled requests, and holds one surviving response while the consumer stalls.

## Interface
Parameters:
- LANES, 2, number of issue lanes (1..4)
- BUS_W, 256, forward bus width
- RESP_W, 33, response data width
- MAX_DISCARD, 3, maximum pending responses to discard (1..15)
- CNT_W, $clog2(MAX_DISCARD+1), discard counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- pre_valid_i  in  LANES  per-lane valid from previous stage
- now_allowin_i  in  1  this stage accepts new data
- flush_i  in  1  exception flush
- pre_to_ibus  in  BUS_W  forward bus from previous stage
- now_valid_o  out  LANES  registered per-lane valid
- to_now_obus  out  BUS_W  registered forward bus
- cancel_add_i  in  CNT_W  number of in-flight requests cancelled this cycle (0 = none)
- resp_valid_i  in  1  response arrives (single-cycle)
- resp_data_i  in  RESP_W  response data
- resp_ready_i  in  1  consumer takes resp_data_o this cycle
- resp_valid_o  out  1  filtered response valid
- resp_data_o  out  RESP_W  filtered response data
- discard_cnt_o  out  CNT_W  pending discard count
- discard_busy_o  out  1  discard_cnt_o != 0
- err_o  out  2  sticky errors: [0] discard counter saturation, [1] hold-buffer overrun

## Operation
- Forward bus: loads pre_to_ibus when (|pre_valid_i) && now_allowin_i; otherwise holds. flush_i does not clear the bus.
- Valids: flush_i → all 0 (highest priority); else now_allowin_i → pre_valid_i; else hold.
- drop = resp_valid_i && (discard_cnt != 0). A dropped response never reaches resp_valid_o or the buffer.
- Counter next = discard_cnt + cancel_add_i − drop, computed in CNT_W+1 bits. If result > MAX_DISCARD → saturate to MAX_DISCARD, set err_o[0]. Simultaneous add and drop are legal and net out.
- accept = resp_valid_i && !drop.
- Hold buffer (buf_v, buf_d):
  - resp_valid_o = buf_v | accept
  - resp_data_o = buf_v ? buf_d : resp_data_i (buffer has priority)
  - buf_v=0, accept, !resp_ready_i → capture resp_data_i, buf_v=1.
  - buf_v=1, resp_ready_i, accept → reload buffer with resp_data_i, buf_v stays 1.
  - buf_v=1, resp_ready_i, no accept → buf_v=0.
  - buf_v=1, !resp_ready_i, accept → keep old data, set err_o[1], new response lost.
- flush_i clears buf_v but not discard_cnt; the caller cancels in-flight requests via cancel_add_i in the same cycle.
- err_o bits are sticky and cleared only by rst.

## Timing
- Reset values: now_valid_o=0, to_now_obus=0, discard_cnt_o=0, discard_busy_o=0, err_o=0, buf_v=0, buf_d=0. resp_valid_o=0 unless resp_valid_i is asserted during reset, in which case it passes combinationally (counter is 0).
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- Forward path latency: 1 cycle.
- resp_valid_o/resp_data_o are combinational from resp_valid_i when the buffer is empty, giving 0-cycle pass-through. A buffered response appears from the cycle after capture.
- cancel_add_i in cycle N first affects drop in cycle N+1. A response in cycle N is judged against the count registered before N.
- discard_busy_o and discard_cnt_o are registered.

## Test plan
- Reset and valid flow: LANES=2. pre_valid_i=2'b11, allowin=1, bus=0xA5.. → next cycle now_valid_o=11, bus=0xA5..; allowin=0 with new data → both hold.
- Flush priority: flush_i=1, allowin=1, pre_valid_i=11 → now_valid_o=00 next cycle; bus still loads.
- Discard counting: cancel_add_i=2 → cnt=2. Two responses 0x1, 0x2 → both dropped, resp_valid_o=0, cnt 2→1→0. Third response 0x3 → passes.
- Simultaneous events and saturation: cnt=1, response plus cancel_add_i=1 in the same cycle → dropped, cnt stays 1. MAX_DISCARD=3, cnt=3 with cancel_add_i=2 → cnt=3, err_o[0]=1.
- Hold buffer: response 0x10 with resp_ready_i=0 → buffered, resp_valid_o=1 next cycle with data 0x10. Ready plus new 0x11 → 0x10 consumed, 0x11 buffered. A new response while stalled → err_o[1]=1, data stays 0x11.
- Async reset mid-stream: assert rst between clock edges with cnt=2 and buffer full → all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_reg_discard.sv
// Inter-stage pipeline register with per-lane valids and flush, plus a read-response
// filter that discards responses of cancelled requests and holds one survivor on stall.
module pipe_stage_reg_discard #(
  parameter int LANES       = 2,
  parameter int BUS_W       = 256,
  parameter int RESP_W      = 33,
  parameter int MAX_DISCARD = 3,
  localparam int CNT_W      = $clog2(MAX_DISCARD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  pre_valid_i,
  input  logic              now_allowin_i,
  input  logic              flush_i,
  input  logic [BUS_W-1:0]  pre_to_ibus,
  output logic [LANES-1:0]  now_valid_o,
  output logic [BUS_W-1:0]  to_now_obus,
  input  logic [CNT_W-1:0]  cancel_add_i,
  input  logic              resp_valid_i,
  input  logic [RESP_W-1:0] resp_data_i,
  input  logic              resp_ready_i,
  output logic              resp_valid_o,
  output logic [RESP_W-1:0] resp_data_o,
  output logic [CNT_W-1:0]  discard_cnt_o,
  output logic              discard_busy_o,
  output logic [1:0]        err_o
);

  localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_DISCARD);

  logic              drop;
  logic              accept;
  logic [CNT_W:0]    cnt_sum;
  logic              cnt_sat;
  logic [CNT_W-1:0]  cnt_next;
  logic              buf_v;
  logic [RESP_W-1:0] buf_d;
  logic              buf_v_next;
  logic              buf_load;
  logic              overrun;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_valid_o <= '0;
      to_now_obus <= '0;
    end else begin
      if (flush_i)            now_valid_o <= '0;
      else if (now_allowin_i) now_valid_o <= pre_valid_i;
      // The bus keeps loading during flush; the cleared valids already kill it.
      if ((|pre_valid_i) && now_allowin_i) to_now_obus <= pre_to_ibus;
    end
  end

  // A response is judged against the count registered before this cycle.
  assign drop   = resp_valid_i && (discard_cnt_o != '0);
  assign accept = resp_valid_i && !drop;

  // One extra bit holds the unsaturated sum; drop only occurs with a nonzero count,
  // so the subtraction cannot underflow.
  assign cnt_sum  = {1'b0, discard_cnt_o} + {1'b0, cancel_add_i} - {{CNT_W{1'b0}}, drop};
  assign cnt_sat  = cnt_sum > MAX_EXT;
  assign cnt_next = cnt_sat ? MAX_EXT[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

  assign resp_valid_o = buf_v | accept;
  assign resp_data_o  = buf_v ? buf_d : resp_data_i;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    buf_v_next = buf_v;
    buf_load   = 1'b0;
    overrun    = buf_v && !resp_ready_i && accept;
    if (flush_i) begin
      buf_v_next = 1'b0;
    end else if (!buf_v) begin
      if (accept && !resp_ready_i) begin
        buf_v_next = 1'b1;
        buf_load   = 1'b1;
      end
    end else if (resp_ready_i) begin
      buf_v_next = accept;
      buf_load   = accept;
    end
  end

  // NOTE: the held data word is reset as well, so resp_data_o never shows X from an
  // unloaded buffer; it is a single register, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v          <= 1'b0;
      buf_d          <= '0;
      discard_cnt_o  <= '0;
      discard_busy_o <= 1'b0;
      err_o          <= 2'b00;
    end else begin
      buf_v          <= buf_v_next;
      if (buf_load) buf_d <= resp_data_i;
      discard_cnt_o  <= cnt_next;
      discard_busy_o <= (cnt_next != '0);
      if (cnt_sat) err_o[0] <= 1'b1;
      if (overrun) err_o[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg_discard.sv
// Self-checking bench: directed test-plan steps followed by randomized traffic, all
// compared against a queue-based behavioural model of the stage.
module tb_pipe_stage_reg_discard;

  localparam int LANES  = 2;
  localparam int BUS_W  = 256;
  localparam int RESP_W = 33;
  localparam int MAXD   = 3;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [LANES-1:0]  pre_valid_i;
  logic              now_allowin_i;
  logic              flush_i;
  logic [BUS_W-1:0]  pre_to_ibus;
  logic [LANES-1:0]  now_valid_o;
  logic [BUS_W-1:0]  to_now_obus;
  logic [CNT_W-1:0]  cancel_add_i;
  logic              resp_valid_i;
  logic [RESP_W-1:0] resp_data_i;
  logic              resp_ready_i;
  logic              resp_valid_o;
  logic [RESP_W-1:0] resp_data_o;
  logic [CNT_W-1:0]  discard_cnt_o;
  logic              discard_busy_o;
  logic [1:0]        err_o;

  pipe_stage_reg_discard #(
    .LANES(LANES), .BUS_W(BUS_W), .RESP_W(RESP_W), .MAX_DISCARD(MAXD)
  ) dut (
    .clk(clk), .rst(rst),
    .pre_valid_i(pre_valid_i), .now_allowin_i(now_allowin_i), .flush_i(flush_i),
    .pre_to_ibus(pre_to_ibus), .now_valid_o(now_valid_o), .to_now_obus(to_now_obus),
    .cancel_add_i(cancel_add_i), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .resp_ready_i(resp_ready_i), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .discard_cnt_o(discard_cnt_o), .discard_busy_o(discard_busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  int                m_cnt;
  logic [RESP_W-1:0] m_bufq[$];
  logic [1:0]        m_err;
  logic [LANES-1:0]  m_valid;
  logic [BUS_W-1:0]  m_bus;

  task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_bufq.delete();
    m_err = 2'b00;
    m_valid = '0;
    m_bus = '0;
  endtask

  function automatic logic m_accept();
    return resp_valid_i && (m_cnt == 0);
  endfunction

  task automatic model_edge();
    logic acc;
    logic drop;
    int   nc;
    acc  = m_accept();
    drop = resp_valid_i && (m_cnt != 0);
    nc = m_cnt + int'(cancel_add_i) - (drop ? 1 : 0);
    if (nc > MAXD) begin
      nc = MAXD;
      m_err[0] = 1'b1;
    end
    m_cnt = nc;
    if (m_bufq.size() != 0 && !resp_ready_i && acc) m_err[1] = 1'b1;
    if (flush_i) m_bufq.delete();
    else if (m_bufq.size() == 0) begin
      if (acc && !resp_ready_i) m_bufq.push_back(resp_data_i);
    end else if (resp_ready_i) begin
      void'(m_bufq.pop_front());
      if (acc) m_bufq.push_back(resp_data_i);
    end
    if (flush_i) m_valid = '0;
    else if (now_allowin_i) m_valid = pre_valid_i;
    if ((|pre_valid_i) && now_allowin_i) m_bus = pre_to_ibus;
  endtask

  task automatic check_comb();
    logic exp_v;
    exp_v = (m_bufq.size() != 0) || m_accept();
    check("resp_valid_o", BUS_W'(resp_valid_o), BUS_W'(exp_v));
    if (exp_v)
      check("resp_data_o", BUS_W'(resp_data_o),
            BUS_W'((m_bufq.size() != 0) ? m_bufq[0] : resp_data_i));
  endtask

  task automatic check_regs();
    check("now_valid_o", BUS_W'(now_valid_o), BUS_W'(m_valid));
    check("to_now_obus", to_now_obus, m_bus);
    check("discard_cnt_o", BUS_W'(discard_cnt_o), BUS_W'(m_cnt));
    check("discard_busy_o", BUS_W'(discard_busy_o), BUS_W'(m_cnt != 0));
    check("err_o", BUS_W'(err_o), BUS_W'(m_err));
  endtask

  // One clock: check combinational outputs with current inputs, clock, check registers.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    pre_valid_i = '0; now_allowin_i = 1'b0; flush_i = 1'b0; pre_to_ibus = '0;
    cancel_add_i = '0; resp_valid_i = 1'b0; resp_data_i = '0; resp_ready_i = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    // Reset state, with a response passing straight through during reset
    resp_valid_i = 1'b1;
    resp_data_i  = 33'h5;
    #12;
    check_regs();
    check("rst pass valid", BUS_W'(resp_valid_o), BUS_W'(1'b1));
    check("rst pass data", BUS_W'(resp_data_o), BUS_W'(33'h5));
    resp_valid_i = 1'b0;
    #1;
    check("rst resp_valid_o", BUS_W'(resp_valid_o), BUS_W'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Valid flow and hold
    pre_valid_i = 2'b11; now_allowin_i = 1'b1; pre_to_ibus = {32{8'hA5}};
    cycle();
    check("flow valid", BUS_W'(now_valid_o), BUS_W'(2'b11));
    check("flow bus", to_now_obus, {32{8'hA5}});
    now_allowin_i = 1'b0; pre_valid_i = 2'b01; pre_to_ibus = {32{8'h5A}};
    cycle();
    check("hold valid", BUS_W'(now_valid_o), BUS_W'(2'b11));
    check("hold bus", to_now_obus, {32{8'hA5}});

    // Flush priority: valids cleared, bus still loads
    flush_i = 1'b1; now_allowin_i = 1'b1; pre_valid_i = 2'b11; pre_to_ibus = {32{8'h3C}};
    cycle();
    check("flush valid", BUS_W'(now_valid_o), BUS_W'(2'b00));
    check("flush bus", to_now_obus, {32{8'h3C}});
    idle_inputs();

    // Discard counting
    cancel_add_i = 2'd2;
    cycle();
    check("cnt after add", BUS_W'(discard_cnt_o), BUS_W'(2));
    cancel_add_i = '0;
    for (int i = 1; i <= 3; i++) begin
      resp_valid_i = 1'b1; resp_data_i = RESP_W'(i);
      #1;
      check("drop/pass valid", BUS_W'(resp_valid_o), BUS_W'(i == 3));
      cycle();
    end
    check("cnt drained", BUS_W'(discard_cnt_o), BUS_W'(0));
    resp_valid_i = 1'b0;

    // Simultaneous add/drop, then saturation
    cancel_add_i = 2'd1;
    cycle();
    resp_valid_i = 1'b1; resp_data_i = 33'h7;
    cycle();
    check("add+drop cnt", BUS_W'(discard_cnt_o), BUS_W'(1));
    resp_valid_i = 1'b0; cancel_add_i = 2'd2;
    cycle();
    check("cnt at max", BUS_W'(discard_cnt_o), BUS_W'(3));
    check("no sat err", BUS_W'(err_o), BUS_W'(2'b00));
    cycle();
    check("sat cnt", BUS_W'(discard_cnt_o), BUS_W'(3));
    check("sat err", BUS_W'(err_o), BUS_W'(2'b01));
    cancel_add_i = '0; resp_valid_i = 1'b1;
    repeat (3) cycle();
    resp_valid_i = 1'b0;

    // Hold buffer: capture, consume+reload, overrun
    resp_valid_i = 1'b1; resp_data_i = 33'h10; resp_ready_i = 1'b0;
    cycle();
    resp_valid_i = 1'b0;
    #1;
    check("buf valid", BUS_W'(resp_valid_o), BUS_W'(1'b1));
    check("buf data", BUS_W'(resp_data_o), BUS_W'(33'h10));
    resp_valid_i = 1'b1; resp_data_i = 33'h11; resp_ready_i = 1'b1;
    cycle();
    check("reload data", BUS_W'(resp_data_o), BUS_W'(33'h11));
    resp_data_i = 33'h12; resp_ready_i = 1'b0;
    cycle();
    check("overrun err", BUS_W'(err_o), BUS_W'(2'b11));
    check("overrun data", BUS_W'(resp_data_o), BUS_W'(33'h11));

    // Asynchronous reset mid-cycle with cnt=2 and buffer full
    resp_valid_i = 1'b0; cancel_add_i = 2'd2;
    cycle();
    cancel_add_i = '0;
    check("pre-rst cnt", BUS_W'(discard_cnt_o), BUS_W'(2));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_regs();
    check("async rst resp_valid_o", BUS_W'(resp_valid_o), BUS_W'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pre_valid_i   = LANES'($urandom);
      now_allowin_i = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      pre_to_ibus   = {8{$urandom}};
      cancel_add_i  = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : '0;
      resp_valid_i  = $urandom_range(0, 1) == 1;
      resp_data_i   = {$urandom, 1'($urandom)};
      resp_ready_i  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
